// File: rtl/apb_reg_bank.sv
`default_nettype none
// ============================================================================
// Module      : apb_reg_bank
// Description : APB slave register bank with REGWN read/write registers and
//               REGRN read-only status registers. Includes programmable wait
//               states, a two-state transfer FSM, registered RW storage and
//               one-cycle commit strobes (pselw / pselr).
//               Optional feature macro: APB_STRB_EN (byte-lane write strobes
//               through PSTRB).
// Revision    : 1.0 - initial release
// ============================================================================
module apb_reg_bank #(
  parameter int                AWIDTH           = 4,
  parameter int                DWIDTH           = 8,
  parameter int                REGWN            = 5,
  parameter int                REGRN            = 3,
  parameter int                REGR_ADDR_OFFSET = 5,
  parameter int                WAIT_STATES      = 1,
  parameter logic [DWIDTH-1:0] RESET_VAL        = '0
) (
  input  logic                      PCLK,
  input  logic                      PRESETn,
  input  logic                      PSEL,
  input  logic                      PENABLE,
  input  logic                      PWRITE,
  input  logic [AWIDTH-1:0]         PADDR,
  input  logic [DWIDTH-1:0]         PWDATA,
`ifdef APB_STRB_EN
  input  logic [DWIDTH/8-1:0]       PSTRB,
`endif
  output logic [DWIDTH-1:0]         PRDATA,
  output logic                      PREADY,
  output logic                      PSLVERR,
  input  logic [REGRN*DWIDTH-1:0]   regr_d,
  output logic [REGWN*DWIDTH-1:0]   regw_q,
  output logic [REGWN-1:0]          pselw,
  output logic [REGRN-1:0]          pselr
);

  // Address window bounds, widened to 32 bits so decode compares are width-clean.
  localparam logic [31:0] C_RW_END = 32'(REGWN);
  localparam logic [31:0] C_RO_LO  = 32'(REGR_ADDR_OFFSET);
  localparam logic [31:0] C_RO_HI  = 32'(REGR_ADDR_OFFSET + REGRN);

  typedef enum logic [0:0] {
    S_IDLE   = 1'b0,
    S_ACCESS = 1'b1
  } state_t;

  state_t                    state_q, state_d;
  logic [3:0]                cnt_q, cnt_d;
  logic [AWIDTH-1:0]         addr_q, addr_d;
  logic                      write_q, write_d;
  logic [DWIDTH-1:0]         wdata_q, wdata_d;
`ifdef APB_STRB_EN
  logic [DWIDTH/8-1:0]       strb_q, strb_d;
`endif
  logic [REGWN*DWIDTH-1:0]   regw_d;

  logic [31:0]               addr_ext;
  logic                      hit_rw;
  logic                      hit_ro;
  logic                      xfer_err;
  logic                      ready;
  logic                      commit;
  logic                      wr_ok;
  logic [DWIDTH-1:0]         rdata;

  // Decode is driven only by the address captured in the setup phase.
  always_comb begin
    addr_ext = 32'(addr_q);
    hit_rw   = (addr_ext < C_RW_END);
    hit_ro   = (addr_ext >= C_RO_LO) && (addr_ext < C_RO_HI);
    xfer_err = (!hit_rw && !hit_ro) || (write_q && hit_ro);
    ready    = (state_q == S_ACCESS) && (cnt_q == 4'd0);
    commit   = ready && PSEL && PENABLE;
    wr_ok    = commit && write_q && !xfer_err;
  end

  // Read mux over RW storage and RO status inputs.
  always_comb begin
    rdata = '0;
    for (int k = 0; k < REGWN; k++) begin
      if (addr_ext == 32'(k)) rdata = regw_q[k*DWIDTH +: DWIDTH];
    end
    for (int k = 0; k < REGRN; k++) begin
      if (addr_ext == 32'(REGR_ADDR_OFFSET + k)) rdata = regr_d[k*DWIDTH +: DWIDTH];
    end
  end

  // APB response: data and error are only visible while PREADY is high.
  always_comb begin
    PREADY  = ready;
    PSLVERR = ready && xfer_err;
    PRDATA  = (ready && !write_q && !xfer_err) ? rdata : '0;
  end

  // One-cycle commit strobes, raised in the completion cycle of a good transfer.
  always_comb begin
    pselw = '0;
    pselr = '0;
    for (int k = 0; k < REGWN; k++) begin
      if (wr_ok && (addr_ext == 32'(k))) pselw[k] = 1'b1;
    end
    for (int k = 0; k < REGRN; k++) begin
      if (commit && !write_q && !xfer_err && (addr_ext == 32'(REGR_ADDR_OFFSET + k)))
        pselr[k] = 1'b1;
    end
  end

  // Next-state logic for the transfer FSM, wait counter and setup capture.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    addr_d  = addr_q;
    write_d = write_q;
    wdata_d = wdata_q;
`ifdef APB_STRB_EN
    strb_d  = strb_q;
`endif
    case (state_q)
      S_IDLE: begin
        if (PSEL && !PENABLE) begin
          addr_d  = PADDR;
          write_d = PWRITE;
          wdata_d = PWDATA;
`ifdef APB_STRB_EN
          strb_d  = PSTRB;
`endif
          cnt_d   = 4'(WAIT_STATES);
          state_d = S_ACCESS;
        end
      end
      S_ACCESS: begin
        if (!PSEL) begin
          // Master abandoned the transfer: return without side effects.
          state_d = S_IDLE;
        end else begin
          if (cnt_q != 4'd0) cnt_d = cnt_q - 4'd1;
          if (commit) state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Next value of RW storage: update the addressed word (or its enabled lanes).
  always_comb begin
    regw_d = regw_q;
    for (int k = 0; k < REGWN; k++) begin
      if (wr_ok && (addr_ext == 32'(k))) begin
`ifdef APB_STRB_EN
        for (int b = 0; b < DWIDTH/8; b++) begin
          if (strb_q[b]) regw_d[k*DWIDTH + b*8 +: 8] = wdata_q[b*8 +: 8];
        end
`else
        regw_d[k*DWIDTH +: DWIDTH] = wdata_q;
`endif
      end
    end
  end

  // State and storage registers with asynchronous active-low reset.
  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      state_q <= S_IDLE;
      cnt_q   <= 4'd0;
      addr_q  <= '0;
      write_q <= 1'b0;
      wdata_q <= '0;
`ifdef APB_STRB_EN
      strb_q  <= '0;
`endif
      regw_q  <= {REGWN{RESET_VAL}};
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      addr_q  <= addr_d;
      write_q <= write_d;
      wdata_q <= wdata_d;
`ifdef APB_STRB_EN
      strb_q  <= strb_d;
`endif
      regw_q  <= regw_d;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_apb_reg_bank.sv
`default_nettype none
// ============================================================================
// Module      : tb_apb_reg_bank
// Description : Directed self-checking bench for apb_reg_bank (default
//               parameters: 8-bit data, 5 RW, 3 RO at 5..7, 1 wait state).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_apb_reg_bank;

  logic        PCLK;
  logic        PRESETn;
  logic        PSEL;
  logic        PENABLE;
  logic        PWRITE;
  logic [3:0]  PADDR;
  logic [7:0]  PWDATA;
`ifdef APB_STRB_EN
  logic [0:0]  PSTRB;
`endif
  logic [7:0]  PRDATA;
  logic        PREADY;
  logic        PSLVERR;
  logic [23:0] regr_d;
  logic [39:0] regw_q;
  logic [4:0]  pselw;
  logic [2:0]  pselr;

  int checks = 0;
  int errors = 0;

  // Results captured by apb_xfer
  logic [7:0]  r_rdata;
  logic        r_err;
  logic [4:0]  r_pselw;
  logic [2:0]  r_pselr;
  int          r_waits;
  logic        r_wait_dirty;

  apb_reg_bank dut (
    .PCLK    (PCLK),
    .PRESETn (PRESETn),
    .PSEL    (PSEL),
    .PENABLE (PENABLE),
    .PWRITE  (PWRITE),
    .PADDR   (PADDR),
    .PWDATA  (PWDATA),
`ifdef APB_STRB_EN
    .PSTRB   (PSTRB),
`endif
    .PRDATA  (PRDATA),
    .PREADY  (PREADY),
    .PSLVERR (PSLVERR),
    .regr_d  (regr_d),
    .regw_q  (regw_q),
    .pselw   (pselw),
    .pselr   (pselr)
  );

  initial PCLK = 1'b0;
  always #5 PCLK = ~PCLK;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Full APB transfer. PADDR is scrambled during ACCESS to show decode uses
  // the setup-phase address. Samples are taken on the falling edge.
  task automatic apb_xfer(input logic wr, input logic [3:0] addr, input logic [7:0] data);
    int n;
    r_waits      = 0;
    r_wait_dirty = 1'b0;
    @(posedge PCLK); #1;
    PSEL = 1'b1; PENABLE = 1'b0; PWRITE = wr; PADDR = addr; PWDATA = data;
    @(posedge PCLK); #1;
    PENABLE = 1'b1; PADDR = ~addr; PWDATA = ~data;
    n = 0;
    @(negedge PCLK);
    while (!PREADY && n < 20) begin
      if (PRDATA !== 8'h00 || PSLVERR !== 1'b0) r_wait_dirty = 1'b1;
      r_waits++;
      n++;
      @(negedge PCLK);
    end
    if (!PREADY) begin
      checks++;
      errors++;
      $display("FAIL pready_timeout: observed PREADY=%b expected 1", PREADY);
    end
    r_rdata = PRDATA;
    r_err   = PSLVERR;
    r_pselw = pselw;
    r_pselr = pselr;
    @(posedge PCLK); #1;
    PSEL = 1'b0; PENABLE = 1'b0;
  endtask

  initial begin
    PRESETn = 1'b0;
    PSEL = 1'b0; PENABLE = 1'b0; PWRITE = 1'b0; PADDR = '0; PWDATA = '0;
`ifdef APB_STRB_EN
    PSTRB = 1'b1;
`endif
    regr_d = {8'h77, 8'h3C, 8'h11};
    repeat (3) @(posedge PCLK);
    #1;
    // Reset state
    check("rst_pready",  64'(PREADY),  64'h0);
    check("rst_pslverr", 64'(PSLVERR), 64'h0);
    check("rst_prdata",  64'(PRDATA),  64'h0);
    check("rst_regw",    64'(regw_q),  64'h0);
    check("rst_pselw",   64'(pselw),   64'h0);
    check("rst_pselr",   64'(pselr),   64'h0);
    PRESETn = 1'b1;

    // Reads of every RW register after reset: zero data, one wait state
    for (int a = 0; a < 5; a++) begin
      apb_xfer(1'b0, 4'(a), 8'h00);
      check("rd0_data",  64'(r_rdata), 64'h0);
      check("rd0_err",   64'(r_err),   64'h0);
      check("rd0_waits", 64'(r_waits), 64'd1);
    end

    // Write 0xA5 to reg 2
    apb_xfer(1'b1, 4'd2, 8'hA5);
    check("wr2_err",   64'(r_err),   64'h0);
    check("wr2_pselw", 64'(r_pselw), 64'b00100);
    check("wr2_pselr", 64'(r_pselr), 64'h0);
    check("wr2_regw",  64'(regw_q),  64'h00_00_A5_00_00);
    check("wr2_pulse_gone", 64'(pselw), 64'h0);

    // Read back reg 2; data/error stay zero during the wait cycle
    apb_xfer(1'b0, 4'd2, 8'h00);
    check("rd2_data",  64'(r_rdata), 64'hA5);
    check("rd2_pselr", 64'(r_pselr), 64'h0);
    check("rd2_wait_clean", 64'(r_wait_dirty), 64'h0);

    // RO registers
    apb_xfer(1'b0, 4'd6, 8'h00);
    check("rd6_data",  64'(r_rdata), 64'h3C);
    check("rd6_pselr", 64'(r_pselr), 64'b010);
    check("rd6_err",   64'(r_err),   64'h0);
    apb_xfer(1'b0, 4'd5, 8'h00);
    check("rd5_data",  64'(r_rdata), 64'h11);
    check("rd5_pselr", 64'(r_pselr), 64'b001);
    apb_xfer(1'b0, 4'd7, 8'h00);
    check("rd7_data",  64'(r_rdata), 64'h77);
    check("rd7_pselr", 64'(r_pselr), 64'b100);

    // Write to RO address: error, nothing changes
    apb_xfer(1'b1, 4'd6, 8'hFF);
    check("wr6_err",   64'(r_err),   64'h1);
    check("wr6_pselw", 64'(r_pselw), 64'h0);
    check("wr6_pselr", 64'(r_pselr), 64'h0);
    check("wr6_regw",  64'(regw_q),  64'h00_00_A5_00_00);

    // Out-of-range address 9
    apb_xfer(1'b0, 4'd9, 8'h00);
    check("rd9_err",   64'(r_err),   64'h1);
    check("rd9_data",  64'(r_rdata), 64'h0);
    check("rd9_pselr", 64'(r_pselr), 64'h0);
    apb_xfer(1'b1, 4'd9, 8'h42);
    check("wr9_err",   64'(r_err),   64'h1);
    check("wr9_pselw", 64'(r_pselw), 64'h0);
    check("wr9_regw",  64'(regw_q),  64'h00_00_A5_00_00);

    // Reg 0 write / read back, lowest boundary
    apb_xfer(1'b1, 4'd0, 8'h5A);
    check("wr0_pselw", 64'(r_pselw), 64'b00001);
    check("wr0_regw",  64'(regw_q),  64'h00_00_A5_00_5A);
    apb_xfer(1'b1, 4'd4, 8'hC3);
    check("wr4_pselw", 64'(r_pselw), 64'b10000);
    check("wr4_regw",  64'(regw_q),  64'hC3_00_A5_00_5A);
    apb_xfer(1'b0, 4'd0, 8'h00);
    check("rd0b_data", 64'(r_rdata), 64'h5A);

    // Abort: PSEL dropped while PREADY is still low
    @(posedge PCLK); #1;
    PSEL = 1'b1; PENABLE = 1'b0; PWRITE = 1'b1; PADDR = 4'd1; PWDATA = 8'hEE;
    @(posedge PCLK); #1;
    PENABLE = 1'b1;
    @(negedge PCLK);
    check("abort_wait_pready", 64'(PREADY), 64'h0);
    PSEL = 1'b0; PENABLE = 1'b0;
    @(negedge PCLK);
    check("abort_pready", 64'(PREADY), 64'h0);
    check("abort_pselw",  64'(pselw),  64'h0);
    check("abort_regw",   64'(regw_q), 64'hC3_00_A5_00_5A);
    apb_xfer(1'b0, 4'd1, 8'h00);
    check("abort_rd1",       64'(r_rdata), 64'h00);
    check("abort_rd1_waits", 64'(r_waits), 64'd1);

    // Reset asserted mid-wait
    @(posedge PCLK); #1;
    PSEL = 1'b1; PENABLE = 1'b0; PWRITE = 1'b1; PADDR = 4'd3; PWDATA = 8'h99;
    @(posedge PCLK); #1;
    PENABLE = 1'b1;
    @(negedge PCLK);
    PRESETn = 1'b0;
    #1;
    check("midrst_pready",  64'(PREADY),  64'h0);
    check("midrst_pslverr", 64'(PSLVERR), 64'h0);
    check("midrst_prdata",  64'(PRDATA),  64'h0);
    check("midrst_pselw",   64'(pselw),   64'h0);
    check("midrst_regw",    64'(regw_q),  64'h0);
    PSEL = 1'b0; PENABLE = 1'b0;
    @(posedge PCLK); #1;
    PRESETn = 1'b1;
    apb_xfer(1'b0, 4'd3, 8'h00);
    check("postrst_rd3", 64'(r_rdata), 64'h00);
    check("postrst_err", 64'(r_err),   64'h0);

`ifdef APB_STRB_EN
    // All-zero strobe: no change but pselw still pulses
    apb_xfer(1'b1, 4'd1, 8'h66);
    check("strb1_regw", 64'(regw_q), 64'h00_00_00_66_00);
    PSTRB = 1'b0;
    apb_xfer(1'b1, 4'd1, 8'h99);
    check("strb0_pselw", 64'(r_pselw), 64'b00010);
    check("strb0_regw",  64'(regw_q),  64'h00_00_00_66_00);
    PSTRB = 1'b1;
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  // Global watchdog
  initial begin
    #100000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
`default_nettype wire
